mul_ctrl: RTL and testbench

- Multi-cycle sequencer wrapped around the team's combinational signed 32x32 Booth multiplier (mul32, radix-4, 64-bit product).
- Accepts multiply requests from the CPU control unit over a valid/ready handshake and registers the operands.
- Holds them stable for a programmable number of cycles so the multiplier is a multicycle path, then writes the 64-bit product into dedicated HI/LO registers.
- Adds unsigned-multiply correction, pipeline flush/abort, and direct HI/LO writes (move-to-HI/LO).

---
 rtl/mul_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mul_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
// mul_ctrl: multi-cycle sequencer around the combinational radix-4 Booth
// multiplier mul32. Operands are registered on accept and held stable for
// MUL_CYCLES cycles so the multiplier is a multicycle path; the product
// (optionally corrected for unsigned operands) then lands in HI/LO.

// mul32: combinational signed 32x32 radix-4 Booth multiplier, 64-bit product.
module mul32 (
   input  logic [31:0] m,
   input  logic [31:0] q,
   output logic [63:0] p
);

   // Multiplier with an implicit zero below bit 0, so every Booth group is a
   // plain 3-bit slice.
   logic [32:0] q_ext;
   logic [63:0] m_ext;
   logic [63:0] pp [16];
   logic [63:0] sum_acc;

   assign q_ext = {q, 1'b0};
   assign m_ext = {{32{m[31]}}, m};

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_booth
         logic [2:0]  grp;
         logic [63:0] term;

         assign grp = q_ext[2*gi+2 : 2*gi];

         // Booth recoding of one group into {0, +-1, +-2} times the multiplicand
         always_comb begin
            case (grp)
               3'b001, 3'b010: term = m_ext;
               3'b011:         term = m_ext << 1;
               3'b100:         term = ~(m_ext << 1) + 64'd1;
               3'b101, 3'b110: term = ~m_ext + 64'd1;
               default:        term = '0;
            endcase
         end

         assign pp[gi] = term << (2 * gi);
      end
   endgenerate

   // Reduce the partial products; wrap-around modulo 2^64 is intended
   always_comb begin
      sum_acc = '0;
      for (int i = 0; i < 16; i++) begin
         sum_acc = sum_acc + pp[i];
      end
   end

   assign p = sum_acc;

endmodule

module mul_ctrl #(
   parameter int MUL_CYCLES = 4   // legal range 1..15
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic        op_unsigned,
   input  logic [31:0] m_in,
   input  logic [31:0] q_in,
   input  logic        flush,
   input  logic        hi_wr,
   input  logic        lo_wr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg;
   logic [31:0] m_reg, q_reg;
   logic        uns_reg;
   logic [31:0] hi_reg, lo_reg;
   logic        done_reg;

   logic        accept;
   logic        capture;
   logic [63:0] prod;
   logic [31:0] hi_fix;

   // Flush has priority over capture, so a flushed op never reaches HI/LO.
   assign accept  = (state_reg == S_IDLE) && start_valid && !flush;
   assign capture = (state_reg == S_WAIT) && !flush && (cnt_reg == 4'd0);

   mul32 u_mul (
      .m (m_reg),
      .q (q_reg),
      .p (prod)
   );

   // Unsigned correction only touches the upper word: add q when m's top bit
   // was read as negative, and m when q's top bit was.
   assign hi_fix = prod[63:32]
                 + (uns_reg ? ({32{m_reg[31]}} & q_reg) : 32'd0)
                 + (uns_reg ? ({32{q_reg[31]}} & m_reg) : 32'd0);

   // State register
   always_ff @(posedge clock) begin
      if (clear) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept) state_next = S_WAIT;
         S_WAIT:  if (flush || cnt_reg == 4'd0) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      start_ready = (state_reg == S_IDLE);
      busy        = (state_reg == S_WAIT);
   end

   // Operand latch and hold counter; operands only move on accept
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt_reg <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         uns_reg <= 1'b0;
      end else if (accept) begin
         cnt_reg <= CNT_LOAD;
         m_reg   <= m_in;
         q_reg   <= q_in;
         uns_reg <= op_unsigned;
      end else if (state_reg == S_WAIT && !flush && cnt_reg != 4'd0) begin
         cnt_reg <= cnt_reg - 4'd1;
      end
   end

   // HI/LO registers and done pulse; a capture overrides a same-edge direct write
   always_ff @(posedge clock) begin
      if (clear) begin
         hi_reg   <= '0;
         lo_reg   <= '0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= capture;
         if (capture) begin
            hi_reg <= hi_fix;
            lo_reg <= prod[31:0];
         end else begin
            if (hi_wr) hi_reg <= wdata;
            if (lo_wr) lo_reg <= wdata;
         end
      end
   end

   assign hi   = hi_reg;
   assign lo   = lo_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed tests for mul_ctrl; one MUL_CYCLES=4 instance for the
// main scenarios and one MUL_CYCLES=1 instance for back-to-back operation.
`timescale 1ns/1ps
module tb_mul_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // MUL_CYCLES = 4 instance
   logic        clear, start_valid, op_unsigned, flush, hi_wr, lo_wr;
   logic [31:0] m_in, q_in, wdata;
   logic        start_ready, busy, done;
   logic [31:0] hi, lo;

   // MUL_CYCLES = 1 instance
   logic        b_clear, b_start_valid, b_op_unsigned, b_flush, b_hi_wr, b_lo_wr;
   logic [31:0] b_m_in, b_q_in, b_wdata;
   logic        b_start_ready, b_busy, b_done;
   logic [31:0] b_hi, b_lo;

   mul_ctrl #(.MUL_CYCLES(4)) dut (
      .clock(clk), .clear(clear), .start_valid(start_valid), .start_ready(start_ready),
      .op_unsigned(op_unsigned), .m_in(m_in), .q_in(q_in), .flush(flush),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   mul_ctrl #(.MUL_CYCLES(1)) dut_b (
      .clock(clk), .clear(b_clear), .start_valid(b_start_valid), .start_ready(b_start_ready),
      .op_unsigned(b_op_unsigned), .m_in(b_m_in), .q_in(b_q_in), .flush(b_flush),
      .hi_wr(b_hi_wr), .lo_wr(b_lo_wr), .wdata(b_wdata), .busy(b_busy), .done(b_done),
      .hi(b_hi), .lo(b_lo)
   );

   // Advance past the next rising edge; inputs are driven and outputs sampled here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and let it be accepted at the next edge
   task automatic start_op(input logic [31:0] m, input logic [31:0] q, input logic u);
      m_in = m; q_in = q; op_unsigned = u; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
   endtask

   // Step until done or the cycle budget runs out
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      clear = 1'b1; b_clear = 1'b1;
      tick(); tick();
      clear = 1'b0; b_clear = 1'b0;
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h required 0", {hi, lo}); end
      checks++; if ({done, busy, start_ready} !== 3'b001) begin errors++; $display("FAIL reset_flags: got done/busy/ready=%b required 001", {done, busy, start_ready}); end
      checks++; if ({b_hi, b_lo} !== 64'd0 || {b_done, b_busy, b_start_ready} !== 3'b001) begin errors++; $display("FAIL reset_b: got %h flags %b required 0 / 001", {b_hi, b_lo}, {b_done, b_busy, b_start_ready}); end
      $display("reset: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_signed();
      start_op(32'hFFFF_FFFD, 32'd7, 1'b0);
      checks++; if ({busy, done, start_ready} !== 3'b100) begin errors++; $display("FAIL signed_accept: got busy/done/ready=%b required 100", {busy, done, start_ready}); end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL signed_wait%0d: got busy/done=%b required 10", k, {busy, done}); end
      end
      tick();
      checks++; if ({busy, done, start_ready} !== 3'b011) begin errors++; $display("FAIL signed_done: got busy/done/ready=%b required 011", {busy, done, start_ready}); end
      checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL signed_prod: got %h_%h required ffffffff_ffffffeb", hi, lo); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL signed_pulse: got done=%b required 0", done); end
      $display("mul -3*7 signed: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_unsigned();
      int n;
      start_op(32'hFFFF_FFFF, 32'd2, 1'b1);
      wait_done(n);
      checks++; if (done !== 1'b1 || n != 4) begin errors++; $display("FAIL uns_latency: got done=%b after %0d cycles required 1 after 4", done, n); end
      checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL uns_prod: got %h_%h required 00000001_fffffffe", hi, lo); end
      $display("mul ffffffff*2 unsigned: hi=%h lo=%h", hi, lo);
      tick();
      start_op(32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_done(n);
      checks++; if (done !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sgn_m1x2: got done=%b %h_%h required 1 ffffffff_fffffffe", done, hi, lo); end
      $display("mul -1*2 signed: hi=%h lo=%h", hi, lo);
      tick();
   endtask

   task automatic test_corner();
      int n;
      start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_done(n);
      checks++; if (done !== 1'b1 || hi !== 32'h4000_0000 || lo !== 32'd0) begin errors++; $display("FAIL corner_signed: got done=%b %h_%h required 1 40000000_00000000", done, hi, lo); end
      $display("mul 80000000^2 signed: hi=%h lo=%h", hi, lo);
      tick();
      start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done(n);
      checks++; if (done !== 1'b1 || hi !== 32'h4000_0000 || lo !== 32'd0) begin errors++; $display("FAIL corner_unsigned: got done=%b %h_%h required 1 40000000_00000000", done, hi, lo); end
      $display("mul 80000000^2 unsigned: hi=%h lo=%h", hi, lo);
      tick();
   endtask

   task automatic test_flush();
      hi_wr = 1'b1; wdata = 32'h1111_1111; tick(); hi_wr = 1'b0;
      lo_wr = 1'b1; wdata = 32'h2222_2222; tick(); lo_wr = 1'b0;
      checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_preload: got %h_%h required 11111111_22222222", hi, lo); end
      start_op(32'd5, 32'd6, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if ({start_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL flush_abort: got ready/busy/done=%b required 100", {start_ready, busy, done}); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_nodone%0d: got done=%b required 0", k, done); end
      end
      checks++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_hilo: got %h_%h required 11111111_22222222", hi, lo); end
      $display("flush 5*6: hi=%h lo=%h", hi, lo);
      flush = 1'b1; start_valid = 1'b1; m_in = 32'd7; q_in = 32'd7;
      tick();
      flush = 1'b0; start_valid = 1'b0;
      checks++; if ({busy, start_ready} !== 2'b01) begin errors++; $display("FAIL flush_noaccept: got busy/ready=%b required 01", {busy, start_ready}); end
      tick();
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL flush_idle: got busy/done=%b required 00", {busy, done}); end
      $display("flush with start_valid: busy=%b", busy);
   endtask

   task automatic test_busy_ignore();
      int n;
      start_op(32'd9, 32'd9, 1'b0);
      m_in = 32'd100; q_in = 32'd100; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      wait_done(n);
      checks++; if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd81) begin errors++; $display("FAIL busy_ignore: got done=%b %h_%h required 1 00000000_00000051", done, hi, lo); end
      tick();
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL busy_second: got busy/done=%b required 00", {busy, done}); end
      $display("mul 9*9 with ignored request: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_clear_mid();
      start_op(32'd9, 32'd9, 1'b0);
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL clear_hilo: got %h required 0", {hi, lo}); end
      checks++; if ({done, busy, start_ready} !== 3'b001) begin errors++; $display("FAIL clear_flags: got done/busy/ready=%b required 001", {done, busy, start_ready}); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_quiet%0d: got done/busy=%b%b required 00", k, done, busy); end
      end
      $display("clear mid 9*9: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_back_to_back();
      b_lo_wr = 1'b1; b_wdata = 32'h0000_BEEF; tick(); b_lo_wr = 1'b0;
      checks++; if (b_lo !== 32'h0000_BEEF) begin errors++; $display("FAIL b2b_direct: got %h required 0000beef", b_lo); end
      b_m_in = 32'd3; b_q_in = 32'd4; b_op_unsigned = 1'b0; b_start_valid = 1'b1;
      tick();
      b_m_in = 32'd10; b_q_in = 32'd10;
      checks++; if ({b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL b2b_accept1: got busy/done=%b required 10", {b_busy, b_done}); end
      tick();
      checks++; if ({b_done, b_start_ready} !== 2'b11 || b_lo !== 32'd12) begin errors++; $display("FAIL b2b_done1: got done/ready=%b lo=%h required 11 lo=0000000c", {b_done, b_start_ready}, b_lo); end
      $display("b2b mul 3*4: lo=%h", b_lo);
      tick();
      b_start_valid = 1'b0; b_lo_wr = 1'b1; b_wdata = 32'h0000_DEAD;
      checks++; if ({b_busy, b_done} !== 2'b10) begin errors++; $display("FAIL b2b_accept2: got busy/done=%b required 10", {b_busy, b_done}); end
      tick();
      b_lo_wr = 1'b0;
      checks++; if (b_done !== 1'b1 || b_lo !== 32'd100 || b_hi !== 32'd0) begin errors++; $display("FAIL b2b_done2: got done=%b %h_%h required 1 00000000_00000064", b_done, b_hi, b_lo); end
      $display("b2b mul 10*10 with lo_wr collision: lo=%h", b_lo);
      tick();
      checks++; if (b_done !== 1'b0 || b_lo !== 32'd100) begin errors++; $display("FAIL b2b_after: got done=%b lo=%h required 0 lo=00000064", b_done, b_lo); end
   endtask

   initial begin
      clear = 1'b1; start_valid = 1'b0; op_unsigned = 1'b0; flush = 1'b0;
      hi_wr = 1'b0; lo_wr = 1'b0; m_in = '0; q_in = '0; wdata = '0;
      b_clear = 1'b1; b_start_valid = 1'b0; b_op_unsigned = 1'b0; b_flush = 1'b0;
      b_hi_wr = 1'b0; b_lo_wr = 1'b0; b_m_in = '0; b_q_in = '0; b_wdata = '0;
      test_reset();
      test_signed();
      test_unsigned();
      test_corner();
      test_flush();
      test_busy_ignore();
      test_clear_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
